// File: rtl/ct_spsram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ct_spsram_pkg
// Description : Shared types and helpers for the parametrised single-port
//               SRAM model with taint shadow (ct_spsram_param_shadow).
//               - state_t       : sequencer state (self-clear sweep / run)
//               - lane_width()  : bits covered by one write-mask lane
//               - lanes_divide(): geometry check used at elaboration
// Revision    : 1.0 - initial release
// ============================================================================
package ct_spsram_pkg;

    // Sequencer state: explicit 1-bit encoding.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Number of data bits controlled by one WEN lane.
    function automatic int lane_width(input int data_width, input int we_width);
        return data_width / we_width;
    endfunction

    // True when the lane count evenly partitions the data word.
    function automatic bit lanes_divide(input int data_width, input int we_width);
        return (we_width > 0) && ((data_width % we_width) == 0);
    endfunction

endpackage : ct_spsram_pkg
`default_nettype wire

// File: rtl/ct_spsram_bank.sv
`default_nettype none
// ============================================================================
// Module      : ct_spsram_bank
// Description : One storage array with registered read and lane-masked write.
//               Used for both the data array and the taint shadow array.
//               Lanes flagged in i_lane_we are overwritten with i_wdata;
//               lanes flagged only in i_lane_or are OR-merged with i_wdata
//               (lets the shadow accumulate taint without a separate read).
// Ports       : clk        - clock
//               i_rst_b    - synchronous active-low reset (read register only)
//               i_we       - write strobe
//               i_addr     - shared read/write address
//               i_lane_we  - per-lane overwrite enable (active high)
//               i_lane_or  - per-lane OR-merge enable (active high)
//               i_wdata    - write / merge data
//               i_re       - read strobe; o_rdata holds when low
//               o_rdata    - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module ct_spsram_bank
    import ct_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 44,
    parameter int WE_WIDTH   = 44
) (
    input  logic                  clk,
    input  logic                  i_rst_b,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [WE_WIDTH-1:0]   i_lane_we,
    input  logic [WE_WIDTH-1:0]   i_lane_or,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int c_lane_w = lane_width(DATA_WIDTH, WE_WIDTH);
    localparam int c_depth  = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage carries no reset; contents are cleared by the sweep in the top.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < WE_WIDTH; i++) begin
                if (i_lane_we[i]) begin
                    r_mem[i_addr][i*c_lane_w +: c_lane_w] <= i_wdata[i*c_lane_w +: c_lane_w];
                end else if (i_lane_or[i]) begin
                    r_mem[i_addr][i*c_lane_w +: c_lane_w] <=
                        r_mem[i_addr][i*c_lane_w +: c_lane_w] | i_wdata[i*c_lane_w +: c_lane_w];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_b) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : ct_spsram_bank
`default_nettype wire

// File: rtl/ct_spsram_param_shadow.sv
`default_nettype none
// ============================================================================
// Module      : ct_spsram_param_shadow
// Description : Parametrised single-port SRAM with active-low CEN/GWEN/WEN,
//               per-lane write masking, post-reset self-clear sweep, optional
//               output register stage and a bit-exact taint shadow array.
// Config      : `define CT_SPSRAM_SHADOW_EN to build the shadow array and the
//               Q_t0 taint path; otherwise Q_t0 is tied to 0 and the *_t0
//               inputs are ignored. Q / INIT_DONE timing is build-independent.
// Ports       : CLK, cpurst_b (sync active-low reset)
//               A/A_t0, CEN/CEN_t0, GWEN/GWEN_t0, WEN/WEN_t0, D/D_t0 - access
//               Q/Q_t0   - read data and taint (latency 1, or 2 if PIPE_OUT)
//               INIT_DONE - high once all entries have been cleared
// Revision    : 1.0 - initial release
// ============================================================================
module ct_spsram_param_shadow
    import ct_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 44,
    parameter int WE_WIDTH   = 44,
    parameter int PIPE_OUT   = 0
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [ADDR_WIDTH-1:0] A_t0,
    input  logic                  CEN,
    input  logic                  CEN_t0,
    input  logic                  GWEN,
    input  logic                  GWEN_t0,
    input  logic [WE_WIDTH-1:0]   WEN,
    input  logic [WE_WIDTH-1:0]   WEN_t0,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] D_t0,
    output logic [DATA_WIDTH-1:0] Q,
    output logic [DATA_WIDTH-1:0] Q_t0,
    output logic                  INIT_DONE
);

    localparam bit                    c_geom_ok   = lanes_divide(DATA_WIDTH, WE_WIDTH);
    localparam int                    c_lane_w    = lane_width(DATA_WIDTH, WE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;
    localparam logic [ADDR_WIDTH-1:0] c_cnt_one   = 1;

    generate
        if (!c_geom_ok) begin : g_geom_check
            $error("ct_spsram_param_shadow: WE_WIDTH must divide DATA_WIDTH");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Self-clear sequencer
    // ------------------------------------------------------------------
    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt, w_init_cnt_nxt;
    logic                  r_init_done, w_init_done_nxt;

    always_comb begin
        w_state_nxt     = r_state;
        w_init_cnt_nxt  = r_init_cnt;
        w_init_done_nxt = r_init_done;
        if (r_state == ST_INIT) begin
            w_init_cnt_nxt = r_init_cnt + c_cnt_one;
            // Last entry is cleared on this edge; RUN and INIT_DONE take
            // effect together so the sweep is exactly 2**ADDR_WIDTH edges.
            if (r_init_cnt == c_last_addr) begin
                w_state_nxt     = ST_RUN;
                w_init_done_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!cpurst_b) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_cnt  <= w_init_cnt_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    assign INIT_DONE = r_init_done;

    // ------------------------------------------------------------------
    // Access decode: external controls only count in RUN; during the sweep
    // the banks are driven by the clear counter instead.
    // ------------------------------------------------------------------
    logic                  w_run, w_wr, w_rd, w_bank_we;
    logic [ADDR_WIDTH-1:0] w_bank_addr;
    logic [WE_WIDTH-1:0]   w_lane_we;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_q_s1, w_q_t0_s1;

    assign w_run       = (r_state == ST_RUN);
    assign w_wr        = w_run & ~CEN & ~GWEN;
    assign w_rd        = w_run & ~CEN &  GWEN;
    assign w_bank_we   = ~w_run | w_wr;
    assign w_bank_addr = w_run ? A    : r_init_cnt;
    assign w_lane_we   = w_run ? ~WEN : '1;
    assign w_wdata     = w_run ? D    : '0;

    ct_spsram_bank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .WE_WIDTH   (WE_WIDTH)
    ) u_data_bank (
        .clk       (CLK),
        .i_rst_b   (cpurst_b),
        .i_we      (w_bank_we),
        .i_addr    (w_bank_addr),
        .i_lane_we (w_lane_we),
        .i_lane_or ('0),
        .i_wdata   (w_wdata),
        .i_re      (w_rd),
        .o_rdata   (w_q_s1)
    );

`ifdef CT_SPSRAM_SHADOW_EN
    // ------------------------------------------------------------------
    // Taint shadow
    // ------------------------------------------------------------------
    logic                  w_ctl_taint;
    logic [DATA_WIDTH-1:0] w_sh_wdata, w_sh_rdata;
    logic [WE_WIDTH-1:0]   w_sh_lane_or;
    logic                  r_t0_force;

    // Tainted address or control corrupts every bit touched by the access.
    assign w_ctl_taint = (|A_t0) | CEN_t0 | GWEN_t0;

    always_comb begin
        w_sh_wdata   = '0;
        w_sh_lane_or = '0;
        if (w_run) begin
            for (int i = 0; i < WE_WIDTH; i++) begin
                if (!WEN[i]) begin
                    w_sh_wdata[i*c_lane_w +: c_lane_w] = D_t0[i*c_lane_w +: c_lane_w]
                        | {c_lane_w{WEN_t0[i] | w_ctl_taint}};
                end else begin
                    // Masked lane whose mask bit is tainted may have been
                    // written: merge the data taint into what is stored.
                    w_sh_wdata[i*c_lane_w +: c_lane_w] = D_t0[i*c_lane_w +: c_lane_w];
                    w_sh_lane_or[i] = WEN_t0[i];
                end
            end
        end
    end

    ct_spsram_bank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .WE_WIDTH   (WE_WIDTH)
    ) u_shadow_bank (
        .clk       (CLK),
        .i_rst_b   (cpurst_b),
        .i_we      (w_bank_we),
        .i_addr    (w_bank_addr),
        .i_lane_we (w_lane_we),
        .i_lane_or (w_sh_lane_or),
        .i_wdata   (w_sh_wdata),
        .i_re      (w_rd),
        .o_rdata   (w_sh_rdata)
    );

    // Whole-word taint is kept as a single sticky bit beside the shadow read
    // register: set by a tainted read, or by an idle cycle with CEN_t0;
    // replaced on every read; held on writes and clean idle cycles.
    always_ff @(posedge CLK) begin
        if (!cpurst_b) begin
            r_t0_force <= 1'b0;
        end else if (w_rd) begin
            r_t0_force <= w_ctl_taint;
        end else if (w_run && CEN && CEN_t0) begin
            r_t0_force <= 1'b1;
        end
    end

    assign w_q_t0_s1 = w_sh_rdata | {DATA_WIDTH{r_t0_force}};
`else
    logic w_unused_taint;
    assign w_unused_taint = ^{A_t0, CEN_t0, GWEN_t0, WEN_t0, D_t0};
    assign w_q_t0_s1      = '0;
`endif

    // ------------------------------------------------------------------
    // Optional output stage; always advances, so an idle cycle simply
    // re-captures the held stage-1 value.
    // ------------------------------------------------------------------
    generate
        if (PIPE_OUT != 0) begin : g_pipe_out
            logic [DATA_WIDTH-1:0] r_q_s2, r_q_t0_s2;
            always_ff @(posedge CLK) begin
                if (!cpurst_b) begin
                    r_q_s2    <= '0;
                    r_q_t0_s2 <= '0;
                end else begin
                    r_q_s2    <= w_q_s1;
                    r_q_t0_s2 <= w_q_t0_s1;
                end
            end
            assign Q    = r_q_s2;
            assign Q_t0 = r_q_t0_s2;
        end else begin : g_no_pipe_out
            assign Q    = w_q_s1;
            assign Q_t0 = w_q_t0_s1;
        end
    endgenerate

endmodule : ct_spsram_param_shadow
`default_nettype wire

// File: tb/tb_ct_spsram_param_shadow.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_spsram_param_shadow
// Description : Self-checking bench. Two instances share one stimulus:
//               dut_a (16 x 44, 44 lanes, PIPE_OUT=0) and
//               dut_b (16 x 44, 2 lanes,  PIPE_OUT=1). The 2-bit lane mask is
//               expanded to 44 bits for dut_a so both see the same writes;
//               dut_b must reproduce dut_a's expected output one cycle later.
//               Taint expectations collapse to 0 when CT_SPSRAM_SHADOW_EN is
//               not defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_spsram_param_shadow;

    localparam int AW = 4;
    localparam int DW = 44;

`ifdef CT_SPSRAM_SHADOW_EN
    localparam bit c_sh_en = 1'b1;
`else
    localparam bit c_sh_en = 1'b0;
`endif

    localparam logic [DW-1:0] ONES = '1;
    localparam logic [DW-1:0] LO   = 44'h000_003F_FFFF;
    localparam logic [DW-1:0] HI   = 44'hFFF_FFC0_0000;
    localparam logic [DW-1:0] K    = 44'hABC_DEF0_1234;

    logic          CLK = 1'b0;
    logic          cpurst_b;
    logic [AW-1:0] A, A_t0;
    logic          CEN, CEN_t0, GWEN, GWEN_t0;
    logic [1:0]    wen2, wen_t0_2;
    logic [DW-1:0] wen_a, wen_t0_a;
    logic [DW-1:0] D, D_t0;
    logic [DW-1:0] q_a, qt_a, q_b, qt_b;
    logic          done_a, done_b;

    always #5 CLK = ~CLK;

    assign wen_a    = {{22{wen2[1]}}, {22{wen2[0]}}};
    assign wen_t0_a = {{22{wen_t0_2[1]}}, {22{wen_t0_2[0]}}};

    ct_spsram_param_shadow #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(44), .PIPE_OUT(0)
    ) dut_a (
        .CLK(CLK), .cpurst_b(cpurst_b), .A(A), .A_t0(A_t0),
        .CEN(CEN), .CEN_t0(CEN_t0), .GWEN(GWEN), .GWEN_t0(GWEN_t0),
        .WEN(wen_a), .WEN_t0(wen_t0_a), .D(D), .D_t0(D_t0),
        .Q(q_a), .Q_t0(qt_a), .INIT_DONE(done_a)
    );

    ct_spsram_param_shadow #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(2), .PIPE_OUT(1)
    ) dut_b (
        .CLK(CLK), .cpurst_b(cpurst_b), .A(A), .A_t0(A_t0),
        .CEN(CEN), .CEN_t0(CEN_t0), .GWEN(GWEN), .GWEN_t0(GWEN_t0),
        .WEN(wen2), .WEN_t0(wen_t0_2), .D(D), .D_t0(D_t0),
        .Q(q_b), .Q_t0(qt_b), .INIT_DONE(done_b)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic          cen;
        logic          gwen;
        logic [1:0]    wen;
        logic [DW-1:0] d;
        logic [AW-1:0] a_t0;
        logic          cen_t0;
        logic          gwen_t0;
        logic [1:0]    wen_t0;
        logic [DW-1:0] d_t0;
        logic [DW-1:0] exp_q;
        logic [DW-1:0] exp_qt0;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(input logic [AW-1:0] a, input logic cen, input logic gwen,
                                input logic [1:0] wen, input logic [DW-1:0] d,
                                input logic [AW-1:0] a_t0, input logic cen_t0, input logic gwen_t0,
                                input logic [1:0] wen_t0, input logic [DW-1:0] d_t0,
                                input logic [DW-1:0] exp_q, input logic [DW-1:0] exp_qt0);
        vec_t v;
        v.a = a; v.cen = cen; v.gwen = gwen; v.wen = wen; v.d = d;
        v.a_t0 = a_t0; v.cen_t0 = cen_t0; v.gwen_t0 = gwen_t0; v.wen_t0 = wen_t0; v.d_t0 = d_t0;
        v.exp_q = exp_q; v.exp_qt0 = exp_qt0;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        A = '0; A_t0 = '0; CEN = 1'b1; CEN_t0 = 1'b0; GWEN = 1'b1; GWEN_t0 = 1'b0;
        wen2 = 2'b11; wen_t0_2 = 2'b00; D = '0; D_t0 = '0;
    endtask

    // Aggressive traffic during the sweep: must all be ignored.
    task automatic drive_init_traffic(input int k);
        A = AW'(k); A_t0 = '0; CEN = 1'b0; CEN_t0 = 1'b0; GWEN = k[0]; GWEN_t0 = 1'b0;
        wen2 = 2'b00; wen_t0_2 = 2'b00; D = ONES; D_t0 = ONES;
    endtask

    task automatic apply(input vec_t v);
        A = v.a; CEN = v.cen; GWEN = v.gwen; wen2 = v.wen; D = v.d;
        A_t0 = v.a_t0; CEN_t0 = v.cen_t0; GWEN_t0 = v.gwen_t0; wen_t0_2 = v.wen_t0; D_t0 = v.d_t0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] prev_q, prev_qt, eq, eqt;

        //                 a    cen  gwen wen    d        at0  ct0  gt0  wt0    dt0     exp_q     exp_qt0
        vecs[0]  = mk(4'd5,  0, 0, 2'b00, K,       4'd0, 0, 0, 2'b00, '0,     '0,       '0);
        vecs[1]  = mk(4'd5,  0, 1, 2'b11, '0,      4'd0, 0, 0, 2'b00, '0,     K,        '0);
        vecs[2]  = mk(4'd0,  1, 1, 2'b11, '0,      4'd0, 0, 0, 2'b00, '0,     K,        '0);
        vecs[3]  = mk(4'd3,  0, 0, 2'b00, '0,      4'd0, 0, 0, 2'b00, '0,     K,        '0);
        vecs[4]  = mk(4'd3,  0, 0, 2'b10, ONES,    4'd0, 0, 0, 2'b00, '0,     K,        '0);
        vecs[5]  = mk(4'd3,  0, 1, 2'b11, '0,      4'd0, 0, 0, 2'b00, '0,     LO,       '0);
        vecs[6]  = mk(4'd7,  0, 0, 2'b00, 44'h55,  4'd0, 0, 0, 2'b00, 44'h1,  LO,       '0);
        vecs[7]  = mk(4'd7,  0, 1, 2'b11, '0,      4'd0, 0, 0, 2'b00, '0,     44'h55,   44'h1);
        vecs[8]  = mk(4'd7,  0, 1, 2'b11, '0,      4'd1, 0, 0, 2'b00, '0,     44'h55,   ONES);
        vecs[9]  = mk(4'd5,  0, 1, 2'b11, '0,      4'd0, 0, 0, 2'b00, '0,     K,        '0);
        vecs[10] = mk(4'd0,  1, 1, 2'b11, '0,      4'd0, 1, 0, 2'b00, '0,     K,        ONES);
        vecs[11] = mk(4'd0,  1, 1, 2'b11, '0,      4'd0, 0, 0, 2'b00, '0,     K,        ONES);
        vecs[12] = mk(4'd3,  0, 1, 2'b11, '0,      4'd0, 0, 0, 2'b00, '0,     LO,       '0);
        vecs[13] = mk(4'd7,  0, 0, 2'b11, ONES,    4'd0, 0, 0, 2'b01, 44'h2,  LO,       '0);
        vecs[14] = mk(4'd7,  0, 1, 2'b11, '0,      4'd0, 0, 0, 2'b00, '0,     44'h55,   44'h3);
        vecs[15] = mk(4'd9,  0, 0, 2'b00, 44'h123, 4'd2, 0, 0, 2'b00, '0,     44'h55,   44'h3);
        vecs[16] = mk(4'd9,  0, 1, 2'b11, '0,      4'd0, 0, 0, 2'b00, '0,     44'h123,  ONES);
        vecs[17] = mk(4'd10, 0, 0, 2'b01, ONES,    4'd0, 0, 0, 2'b10, '0,     44'h123,  ONES);
        vecs[18] = mk(4'd10, 0, 1, 2'b11, '0,      4'd0, 0, 0, 2'b00, '0,     HI,       HI);
        vecs[19] = mk(4'd5,  0, 1, 2'b11, '0,      4'd0, 0, 0, 2'b00, '0,     K,        '0);
        vecs[20] = mk(4'd3,  0, 1, 2'b11, '0,      4'd0, 0, 1, 2'b00, '0,     LO,       ONES);
        vecs[21] = mk(4'd15, 0, 1, 2'b11, '0,      4'd0, 0, 0, 2'b00, '0,     '0,       '0);
        vecs[22] = mk(4'd15, 0, 0, 2'b00, 44'h77,  4'd0, 0, 1, 2'b00, '0,     '0,       '0);
        vecs[23] = mk(4'd15, 0, 1, 2'b11, '0,      4'd0, 0, 0, 2'b00, '0,     44'h77,   ONES);

        // Reset state
        cpurst_b = 1'b0;
        set_idle();
        repeat (3) tick();
        check("reset q_a", q_a, '0);
        check("reset qt_a", qt_a, '0);
        check("reset done_a", DW'(done_a), '0);
        check("reset q_b", q_b, '0);
        check("reset qt_b", qt_b, '0);
        check("reset done_b", DW'(done_b), '0);

        // Start a sweep, abort it at cycle 5 with reset, then let it finish.
        cpurst_b = 1'b1;
        drive_init_traffic(0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("init1 done_a", DW'(done_a), '0);
            check("init1 q_a", q_a, '0);
            drive_init_traffic(k);
        end
        cpurst_b = 1'b0;
        tick();
        check("midreset done_a", DW'(done_a), '0);
        check("midreset done_b", DW'(done_b), '0);
        cpurst_b = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            drive_init_traffic(k + 5);
            tick();
            check("init2 done_a", DW'(done_a), (k == 16) ? DW'(1) : '0);
            check("init2 done_b", DW'(done_b), (k == 16) ? DW'(1) : '0);
            check("init2 q_a", q_a, '0);
            check("init2 qt_a", qt_a, '0);
            check("init2 q_b", q_b, '0);
        end
        set_idle();

        // Every entry must be zero after the sweep despite the INIT traffic.
        for (int adr = 0; adr < 16; adr++) begin
            A = AW'(adr); CEN = 1'b0; GWEN = 1'b1;
            tick();
            check("sweep q_a", q_a, '0);
            check("sweep qt_a", qt_a, '0);
            check("sweep q_b", q_b, '0);
            check("sweep qt_b", qt_b, '0);
        end

        // Table: dut_a compares against the row, dut_b against the prior row.
        prev_q  = '0;
        prev_qt = '0;
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i]);
            tick();
            eq  = vecs[i].exp_q;
            eqt = c_sh_en ? vecs[i].exp_qt0 : '0;
            check($sformatf("vec%0d q_a", i), q_a, eq);
            check($sformatf("vec%0d qt_a", i), qt_a, eqt);
            check($sformatf("vec%0d q_b", i), q_b, prev_q);
            check($sformatf("vec%0d qt_b", i), qt_b, prev_qt);
            prev_q  = eq;
            prev_qt = eqt;
        end

        // Two-stage latency: read A=9 then idle; dut_b shows it one edge later.
        set_idle();
        A = 4'd9; CEN = 1'b0; GWEN = 1'b1;
        tick();
        set_idle();
        check("lat q_a", q_a, 44'h123);
        check("lat q_b early", q_b, 44'h77);
        tick();
        check("lat q_b", q_b, 44'h123);
        check("lat q_a hold", q_a, 44'h123);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ct_spsram_param_shadow
`default_nettype wire

// File: doc/ct_spsram_param_shadow.md
Name: ct_spsram_param_shadow

Overview:
- Parametrised single-port SRAM model with active-low chip/write enables, per-lane write masking and a taint shadow array that mirrors the data array bit-for-bit.
- Successor to the fixed-geometry spsram wrappers: width, depth, write-mask granularity and output pipelining are all configurable.
- Adds a post-reset self-clear sequencer, a 1- or 2-cycle read pipeline and real Q_t0 taint propagation in place of a tied-off zero.
- Sits under the cache/TLB array wrappers in the C910 memory subsystem.

Parameters:
ADDR_WIDTH, 9, address bits; depth = 2**ADDR_WIDTH entries
DATA_WIDTH, 44, data bits per entry
WE_WIDTH, 44, write-mask lanes; must divide DATA_WIDTH; lane i covers bits [i*L +: L], where L = DATA_WIDTH/WE_WIDTH
PIPE_OUT, 0, 1 adds an output register stage (read latency 2 instead of 1)

Ports:
CLK  in  1  clock
cpurst_b  in  1  synchronous active-low reset
A  in  ADDR_WIDTH  address
A_t0  in  ADDR_WIDTH  address taint
CEN  in  1  chip enable, active low
CEN_t0  in  1  CEN taint
GWEN  in  1  global write enable, active low (0 = write, 1 = read)
GWEN_t0  in  1  GWEN taint
WEN  in  WE_WIDTH  per-lane write enable, active low
WEN_t0  in  WE_WIDTH  WEN taint
D  in  DATA_WIDTH  write data
D_t0  in  DATA_WIDTH  write-data taint
Q  out  DATA_WIDTH  read data
Q_t0  out  DATA_WIDTH  read-data taint
INIT_DONE  out  1  high once the self-clear sweep has completed

Behaviour:
- Reset (cpurst_b=0 at a CLK edge) forces: Q=0, Q_t0=0, pipeline registers 0, INIT_DONE=0, state=INIT, init counter=0.
- State machine:
  - INIT: each cycle writes 0 to data[cnt] and shadow[cnt], then cnt++.
  - When cnt = 2**ADDR_WIDTH-1 is written, go to RUN and set INIT_DONE=1 on the next cycle.
  - The sweep takes exactly 2**ADDR_WIDTH cycles.
  - RUN: normal operation. RUN never returns to INIT except via reset.
- Reset asserted mid-INIT restarts the sweep from address 0.
- During INIT all CEN/GWEN/WEN inputs are ignored; Q and Q_t0 hold 0.
- Write (RUN, CEN=0, GWEN=0):
  - For each lane with WEN[i]=0, data lane <= D lane.
  - Lanes with WEN[i]=1 are unchanged.
  - Q holds its previous value; there is no read-during-write.
- Read (RUN, CEN=0, GWEN=1): data[A] is registered at the edge.
  - PIPE_OUT=0: Q valid after 1 edge.
  - PIPE_OUT=1: Q valid after 2 edges; the second stage always advances.
- Idle (CEN=1): Q holds its last read value (PIPE_OUT=1: stage 2 captures the held stage-1 value).
- Back-to-back reads: one result per cycle; no stall.
- Address range: full, no out-of-range case; A wraps naturally at ADDR_WIDTH.
- Taint rules (feature enabled):
  - Write, written lane: shadow lane <= D_t0 lane | {L{WEN_t0[i]}} | {L{|A_t0}} | {L{GWEN_t0 | CEN_t0}}.
  - Write, lane with WEN[i]=1: if WEN_t0[i]=1, shadow lane <= shadow lane | D_t0 lane; otherwise unchanged.
  - Read: Q_t0 <= shadow[A] | {DATA_WIDTH{|A_t0 | CEN_t0 | GWEN_t0}}.
  - Idle with CEN_t0=1: Q_t0 <= Q_t0 | all-ones; Q is unchanged.
  - Q_t0 follows the same pipeline latency as Q.

Optional Feature:
- Macro: CT_SPSRAM_SHADOW_EN.
- Defined: shadow array, taint logic and Q_t0 register exist as described above.
- Undefined: no shadow array; Q_t0 is tied to 0. The *_t0 inputs remain as ports and are unused. Q and INIT_DONE timing are identical in both builds.

Decomposition:
- Package ct_spsram_pkg holds:
  - typedef for the state enum {INIT, RUN};
  - function lane_width(DATA_WIDTH, WE_WIDTH);
  - an elaboration-time check constant asserting DATA_WIDTH % WE_WIDTH == 0.
- One natural sub-module: ct_spsram_bank, a single storage array with registered read and lane-masked write. It is instantiated twice (data and shadow); the shadow instance is guarded by the macro.

Test Plan:
1. ADDR_WIDTH=4: release reset -> INIT_DONE rises after exactly 16 cycles; reading addresses 0..15 returns Q=0, Q_t0=0.
2. RUN, PIPE_OUT=0: write A=5, D=44'hABC_DEF0_1234, WEN all 0; then read A=5 -> Q=44'hABC_DEF0_1234 one cycle later. With PIPE_OUT=1 the same value appears two cycles later.
3. WE_WIDTH=2: write 44'h0 to A=3, then write A=3 with D=all-ones and WEN=2'b10 -> read returns low 22 bits set, high 22 bits 0.
4. Shadow: write A=7 with D_t0=44'h1 and clean controls -> read gives Q_t0=44'h1. Read A=7 with A_t0=9'h1 -> Q_t0=all-ones.
5. Assert reset at INIT cycle 5, release -> sweep restarts; INIT_DONE takes the full 2**ADDR_WIDTH cycles from release. Writes issued during INIT leave memory 0.
6. Macro undefined: repeat test 4 -> Q_t0 stays 0; Q matches the shadow-enabled run cycle for cycle.
